trace_capture: RTL and testbench
================================

# trace_capture

Parametrised on-chip execution trace buffer for the skeleton processor. It records one sample per valid cycle: imem address, fetched instruction, and one auxiliary data word (e.g. the writeback value). It can run as a free-running ring or as a triggered capture that stops a programmable number of samples after a PC match. A readout port then lets the bench or the board debug logic replay the window oldest-first, replacing per-cycle console monitoring.

## Interface
- ADDR_W, 12, width of captured imem address
- DATA_W, 32, width of captured instruction and aux word
- DEPTH, 16, buffer entries; power of two, ≥2
- POST_TRIG, 4, samples captured after the trigger sample; 0..DEPTH-1
- clk  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high
- valid_in  in  1  sample qualifier
- pc_in  in  ADDR_W  imem address
- instr_in  in  DATA_W  instruction word
- aux_in  in  DATA_W  auxiliary word
- arm  in  1  clear buffer and start capture
- stop  in  1  force capture end
- mode  in  1  0 = free-run ring, 1 = triggered
- trig_pc  in  ADDR_W  trigger address (mode 1)
- rd_req  in  1  read request
- rd_idx  in  log2(DEPTH)  index relative to oldest entry
- rd_valid  out  1  read data valid
- rd_pc / rd_instr / rd_aux  out  ADDR_W / DATA_W / DATA_W  read data
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count  out  log2(DEPTH)+1  valid entries, saturates at DEPTH
- trig_idx  out  log2(DEPTH)  trigger sample index relative to oldest entry
- triggered  out  1  trigger occurred this capture

## Operation
- Reset: state IDLE; wr_ptr, count, trig_idx, post counter = 0; triggered = 0; rd_valid = 0; rd_* = 0. Buffer contents undefined.
- arm, any state: wr_ptr = 0, count = 0, triggered = 0, trig_idx = 0, next state ARMED. No sample is written in the arm cycle. arm has priority over stop and over trigger.
- ARMED/POST with valid_in = 1: write {pc,instr,aux} at wr_ptr; wr_ptr increments mod DEPTH; count increments and saturates at DEPTH. Once full, the oldest entry is overwritten.
- ARMED, mode 1, valid_in = 1, pc_in == trig_pc: the sample is written and triggered = 1.
  - If POST_TRIG = 0: next state DONE.
  - Otherwise: post counter = POST_TRIG, next state POST.
- trig_idx tracks the trigger sample's position relative to the oldest entry. It decrements (floor 0) each time an overwrite shifts the oldest entry.
- ARMED, mode 0: the trigger is ignored; capture continues until stop.
- POST: each written sample decrements the post counter. The write that takes it to 0 moves the state to DONE. PC matches in POST are ignored.
- stop in ARMED or POST (no arm): next state DONE. The sample in that cycle is still written if valid.
- DONE and IDLE: no writes. Only arm leaves DONE. mode and trig_pc are sampled live, so they are only changed in IDLE or DONE.
- Readout is accepted only in IDLE or DONE.
  - Physical address = (wr_ptr − count + rd_idx) mod DEPTH.
  - rd_idx ≥ count returns zeros with rd_valid = 1.
  - rd_req in ARMED or POST: rd_valid stays 0 and rd_* hold their previous values.

## Timing
- Capture: a sample presented at edge N is in memory and reflected in count after edge N.
- State change on trigger, stop, or arm is visible after the same edge.
- Read latency is 1 cycle. rd_req at edge N gives rd_valid = 1 with data after edge N. rd_valid is a single-cycle pulse per request; back-to-back requests give one result per cycle.
- Reset mid-capture aborts to IDLE on the next edge, with the count reset to 0.

## Test plan
- Reset, DEPTH=8: assert reset 2 cycles → state 0, count 0, rd_valid 0, triggered 0.
- Free-run wrap, mode 0, DEPTH=8: arm, then 11 valid samples with pc 0..10, then stop → state 3, count 8. Reads of idx 0..7 return pc 3..10, oldest first.
- Triggered, DEPTH=8, POST_TRIG=2, trig_pc=5: arm, samples pc 0..9 → DONE after the pc 7 sample. count 8, read pc 0..7, trig_idx 5, triggered 1. pc 8 and 9 are not captured.
- Trigger with wrap, POST_TRIG=2, trig_pc=12: samples pc 0..20 → DONE after pc 14. Reads return pc 7..14, trig_idx 5.
- Gaps and priority:
  - valid_in low on alternate cycles → only valid samples are counted.
  - arm and stop asserted together in POST → state ARMED, count 0.
  - rd_req while ARMED → rd_valid 0.
- Reset during POST → IDLE next edge. A following arm-and-capture sequence behaves identically to the triggered scenario above.

Source files
------------

// File: rtl/trace_capture.sv
// Execution trace buffer: records {pc, instr, aux} per valid cycle as a free-running
// ring or as a PC-triggered window, then replays the window oldest-first.
module trace_capture #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic [ADDR_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          instr_in,
    input  logic [DATA_W-1:0]          aux_in,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       mode,
    input  logic [ADDR_W-1:0]          trig_pc,
    input  logic                       rd_req,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       rd_valid,
    output logic [ADDR_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_instr,
    output logic [DATA_W-1:0]          rd_aux,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   trig_idx,
    output logic                       triggered
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
    logic [DATA_W-1:0] r_mem_instr [DEPTH];
    logic [DATA_W-1:0] r_mem_aux   [DEPTH];

    logic [1:0]        r_state,     w_state_nxt;
    logic [IDX_W-1:0]  r_wr_ptr,    w_wr_ptr_nxt;
    logic [CNT_W-1:0]  r_count,     w_count_nxt;
    logic [IDX_W-1:0]  r_trig_idx,  w_trig_idx_nxt;
    logic [IDX_W-1:0]  r_post,      w_post_nxt;
    logic              r_triggered, w_triggered_nxt;

    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_pc;
    logic [DATA_W-1:0] r_rd_instr;
    logic [DATA_W-1:0] r_rd_aux;

    logic              w_capturing;
    logic              w_write;
    logic              w_full;
    logic              w_hit;
    logic              w_rd_ok;
    logic [IDX_W-1:0]  w_phys;

    assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_write     = w_capturing && valid_in && !arm;
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_hit       = w_write && (r_state == S_ARMED) && mode && (pc_in == trig_pc);
    assign w_rd_ok     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_phys      = r_wr_ptr - r_count[IDX_W-1:0] + rd_idx;

    // Next-state and capture bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_count_nxt     = r_count;
        w_trig_idx_nxt  = r_trig_idx;
        w_post_nxt      = r_post;
        w_triggered_nxt = r_triggered;
        if (arm) begin
            w_state_nxt     = S_ARMED;
            w_wr_ptr_nxt    = '0;
            w_count_nxt     = '0;
            w_trig_idx_nxt  = '0;
            w_post_nxt      = '0;
            w_triggered_nxt = 1'b0;
        end else begin
            if (w_write) begin
                w_wr_ptr_nxt = r_wr_ptr + IDX_W'(1);
                if (!w_full) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end else if (r_trig_idx != '0) begin
                    // overwrite shifts the oldest entry, so the trigger moves one closer
                    w_trig_idx_nxt = r_trig_idx - IDX_W'(1);
                end
            end
            if (w_hit) begin
                w_triggered_nxt = 1'b1;
                w_trig_idx_nxt  = w_full ? IDX_W'(DEPTH - 1) : r_count[IDX_W-1:0];
                if (POST_TRIG == 0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_post_nxt  = IDX_W'(POST_TRIG);
                    w_state_nxt = S_POST;
                end
            end
            if ((r_state == S_POST) && w_write) begin
                w_post_nxt = r_post - IDX_W'(1);
                if (r_post == IDX_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            if (stop && w_capturing) begin
                w_state_nxt = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_trig_idx  <= '0;
            r_post      <= '0;
            r_triggered <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_trig_idx  <= w_trig_idx_nxt;
            r_post      <= w_post_nxt;
            r_triggered <= w_triggered_nxt;
        end
    end

    // Sample storage, contents undefined after reset
    always_ff @(posedge clk) begin
        if (w_write && !reset) begin
            r_mem_pc[r_wr_ptr]    <= pc_in;
            r_mem_instr[r_wr_ptr] <= instr_in;
            r_mem_aux[r_wr_ptr]   <= aux_in;
        end
    end

    // Readout port; requests while capturing are dropped and data holds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_aux   <= '0;
        end else begin
            r_rd_valid <= rd_req && w_rd_ok;
            if (rd_req && w_rd_ok) begin
                if (CNT_W'(rd_idx) < r_count) begin
                    r_rd_pc    <= r_mem_pc[w_phys];
                    r_rd_instr <= r_mem_instr[w_phys];
                    r_rd_aux   <= r_mem_aux[w_phys];
                end else begin
                    r_rd_pc    <= '0;
                    r_rd_instr <= '0;
                    r_rd_aux   <= '0;
                end
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_pc     = r_rd_pc;
    assign rd_instr  = r_rd_instr;
    assign rd_aux    = r_rd_aux;
    assign state     = r_state;
    assign count     = r_count;
    assign trig_idx  = r_trig_idx;
    assign triggered = r_triggered;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: directed scenarios plus random traffic checked against a
// queue-based model of the captured window.
module tb_trace_capture;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned POST_TRIG = 2;
    localparam int unsigned IDX_W     = $clog2(DEPTH);

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] aux;
    } samp_t;

    logic              clk = 1'b0;
    logic              reset, valid_in, arm, stop, mode, rd_req;
    logic [ADDR_W-1:0] pc_in, trig_pc;
    logic [DATA_W-1:0] instr_in, aux_in;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid, triggered;
    logic [ADDR_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr, rd_aux;
    logic [1:0]        state;
    logic [IDX_W:0]    count;
    logic [IDX_W-1:0]  trig_idx;

    trace_capture #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
        .instr_in(instr_in), .aux_in(aux_in), .arm(arm), .stop(stop),
        .mode(mode), .trig_pc(trig_pc), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_aux(rd_aux),
        .state(state), .count(count), .trig_idx(trig_idx), .triggered(triggered)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the window is a queue of samples, the trigger an absolute sequence number
    samp_t             m_q[$];
    int                m_state, m_total, m_trig_seq, m_post_left;
    bit                m_trig, m_rd_valid;
    logic [ADDR_W-1:0] m_rd_pc;
    logic [DATA_W-1:0] m_rd_instr, m_rd_aux;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int exp_trig_idx();
        int rel;
        if (m_trig_seq < 0) return 0;
        rel = m_trig_seq - (m_total - m_q.size());
        return (rel < 0) ? 0 : rel;
    endfunction

    task automatic model_update();
        samp_t s;
        int ns;
        if (reset) begin
            m_q.delete(); m_state = 0; m_total = 0; m_trig_seq = -1; m_post_left = 0;
            m_trig = 0; m_rd_valid = 0; m_rd_pc = '0; m_rd_instr = '0; m_rd_aux = '0;
            return;
        end
        m_rd_valid = rd_req && (m_state == 0 || m_state == 3);
        if (m_rd_valid) begin
            if (int'(rd_idx) < m_q.size()) begin
                m_rd_pc = m_q[rd_idx].pc; m_rd_instr = m_q[rd_idx].instr; m_rd_aux = m_q[rd_idx].aux;
            end else begin
                m_rd_pc = '0; m_rd_instr = '0; m_rd_aux = '0;
            end
        end
        if (arm) begin
            m_q.delete(); m_total = 0; m_trig = 0; m_trig_seq = -1; m_state = 1;
            return;
        end
        ns = m_state;
        if (m_state == 1 || m_state == 2) begin
            if (valid_in) begin
                s.pc = pc_in; s.instr = instr_in; s.aux = aux_in;
                m_q.push_back(s);
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
                m_total++;
                if (m_state == 1 && mode && pc_in == trig_pc) begin
                    m_trig = 1; m_trig_seq = m_total - 1;
                    if (POST_TRIG == 0) ns = 3;
                    else begin m_post_left = POST_TRIG; ns = 2; end
                end else if (m_state == 2) begin
                    m_post_left--;
                    if (m_post_left == 0) ns = 3;
                end
            end
            if (stop) ns = 3;
        end
        m_state = ns;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("state", 64'(state), 64'(m_state));
        check("count", 64'(count), 64'(m_q.size()));
        check("triggered", 64'(triggered), 64'(m_trig));
        check("trig_idx", 64'(trig_idx), 64'(exp_trig_idx()));
        check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        check("rd_pc", 64'(rd_pc), 64'(m_rd_pc));
        check("rd_instr", 64'(rd_instr), 64'(m_rd_instr));
        check("rd_aux", 64'(rd_aux), 64'(m_rd_aux));
    endtask

    task automatic quiet();
        reset = 0; valid_in = 0; arm = 0; stop = 0; rd_req = 0; rd_idx = '0;
        pc_in = '0; instr_in = '0; aux_in = '0;
    endtask

    task automatic push(input int pc);
        valid_in = 1; pc_in = ADDR_W'(pc); instr_in = $urandom; aux_in = $urandom;
        step();
        valid_in = 0;
    endtask

    task automatic do_arm();
        arm = 1; step(); arm = 0;
    endtask

    task automatic read_window(input string tag, input int n, input int base_pc);
        for (int i = 0; i < n; i++) begin
            rd_req = 1; rd_idx = IDX_W'(i);
            step();
            check(tag, 64'(rd_pc), 64'(base_pc + i));
        end
        rd_req = 0;
    endtask

    task automatic triggered_run();
        mode = 1; trig_pc = ADDR_W'(5);
        do_arm();
        for (int p = 0; p < 10; p++) push(p);
        check("trg_state", 64'(state), 64'd3);
        check("trg_count", 64'(count), 64'd8);
        check("trg_idx", 64'(trig_idx), 64'd5);
        check("trg_flag", 64'(triggered), 64'd1);
        read_window("trg_rd", 8, 0);
    endtask

    initial begin
        quiet(); mode = 0; trig_pc = '0;
        m_trig_seq = -1;

        reset = 1; step(); step(); reset = 0;
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rdv", 64'(rd_valid), 64'd0);

        mode = 0;
        do_arm();
        for (int p = 0; p <= 10; p++) begin
            valid_in = 1; pc_in = ADDR_W'(p); instr_in = $urandom; aux_in = $urandom; step();
        end
        valid_in = 0; stop = 1; step(); stop = 0;
        check("fr_state", 64'(state), 64'd3);
        check("fr_count", 64'(count), 64'd8);
        read_window("fr_rd", 8, 3);

        triggered_run();

        mode = 1; trig_pc = ADDR_W'(12);
        do_arm();
        for (int p = 0; p <= 20; p++) push(p);
        check("wrap_idx", 64'(trig_idx), 64'd5);
        read_window("wrap_rd", 8, 7);

        mode = 0;
        do_arm();
        for (int i = 0; i < 6; i++) begin
            valid_in = (i % 2 == 0); pc_in = ADDR_W'(i); step();
        end
        valid_in = 0;
        check("gap_count", 64'(count), 64'd3);
        rd_req = 1; rd_idx = '0; step(); rd_req = 0;
        check("rd_armed", 64'(rd_valid), 64'd0);
        stop = 1; step(); stop = 0;

        mode = 1; trig_pc = ADDR_W'(5);
        do_arm();
        for (int p = 0; p <= 5; p++) push(p);
        check("post_state", 64'(state), 64'd2);
        arm = 1; stop = 1; step(); arm = 0; stop = 0;
        check("armstop_state", 64'(state), 64'd1);
        check("armstop_count", 64'(count), 64'd0);

        for (int p = 0; p <= 5; p++) push(p);
        reset = 1; step(); reset = 0;
        check("rstpost_state", 64'(state), 64'd0);
        check("rstpost_count", 64'(count), 64'd0);
        triggered_run();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            quiet();
            if (m_state == 0 || m_state == 3) begin
                if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
                if ($urandom_range(0, 7) == 0) trig_pc = ADDR_W'($urandom_range(0, 15));
                arm = ($urandom_range(0, 9) == 0);
            end else begin
                arm = ($urandom_range(0, 59) == 0);
            end
            reset    = ($urandom_range(0, 299) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            valid_in = ($urandom_range(0, 9) < 7);
            pc_in    = ADDR_W'($urandom_range(0, 15));
            instr_in = $urandom;
            aux_in   = $urandom;
            rd_req   = ($urandom_range(0, 9) < 4);
            rd_idx   = IDX_W'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
